regfile_wr_sched: RTL and testbench

- Write-port scheduler for a register file built from per-entry enable/sync-reset registers.
- Shares the single write path between NUM_REQ requesters using round-robin arbitration with valid/ready handshakes.
- Drives one-hot per-entry enables plus common write data.
- Owns an init sweep that writes INIT_VAL to every entry after reset or on request.

---
 rtl/regfile_wr_sched_pkg.sv | 22 ++
 rtl/regfile_wr_sched_rr_arbiter.sv | 53 +++++
 rtl/regfile_wr_sched.sv | 130 +++++++++++++
 tb/tb_regfile_wr_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_sched_pkg.sv
// Shared types and helpers for the register-file write-port scheduler.
package regfile_wr_sched_pkg;

    typedef enum logic {
        INIT = 1'b0,
        ARB  = 1'b1
    } sched_state_t;

    // Decoder width ceiling; instances must keep DEPTH below this.
    localparam int RF_MAX_DEPTH = 256;

    // One-hot decode of an entry address; callers slice the low DEPTH bits.
    function automatic logic [RF_MAX_DEPTH-1:0] onehot_dec(input int unsigned addr);
        logic [RF_MAX_DEPTH-1:0] vec;
        vec = '0;
        for (int unsigned i = 0; i < RF_MAX_DEPTH; i++) begin
            vec[i] = (addr == i);
        end
        return vec;
    endfunction

endpackage

// File: rtl/regfile_wr_sched_rr_arbiter.sv
// Round-robin arbiter: searches upward from its pointer, which moves past
// the winner only when the caller reports an accepted grant.
module rr_arbiter
    import regfile_wr_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] idx;
    logic            found;

    // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // NOTE: every output gets a default before any branch, so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler: init sweep after reset or on request, then
// round-robin sharing of the single register-file write path.
module regfile_wr_sched
    import regfile_wr_sched_pkg::*;
#(
    parameter  int               NUM_REQ  = 4,
    parameter  int               DEPTH    = 16,
    parameter  int               WIDTH    = 32,
    parameter  logic [WIDTH-1:0] INIT_VAL = '0,
    localparam int               ADDR_W   = $clog2(DEPTH),
    localparam int               ID_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]  req_data,
    input  logic                      init_start,
    output logic                      init_busy,
    output logic [DEPTH-1:0]          rf_we,
    output logic [WIDTH-1:0]          rf_wdata,
    output logic [ID_W-1:0]           wr_grant_id,
    output logic                      wr_err
);

    sched_state_t      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0]  rf_we_q, rf_we_d;
    logic [WIDTH-1:0]  rf_wdata_q, rf_wdata_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              wr_err_q, wr_err_d;

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [WIDTH-1:0]  data_arr [NUM_REQ];

    logic [NUM_REQ-1:0]      arb_grant;
    logic [ID_W-1:0]         arb_idx;
    logic                    arb_open;
    logic                    arb_advance;
    logic [ADDR_W-1:0]       dec_addr;
    logic [RF_MAX_DEPTH-1:0] dec_full;
    logic                    addr_oor;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
            data_arr[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (arb_advance),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // A re-init request closes the write path in the very cycle it arrives.
    assign arb_open    = (state_q == ARB) && !rst && !init_start;
    assign req_ready   = arb_open ? arb_grant : '0;
    assign arb_advance = arb_open && (|arb_grant);
    assign init_busy   = (state_q == INIT);

    // One decoder serves both the sweep and granted writes; any hit above
    // DEPTH-1 marks an address with no backing entry.
    assign dec_addr = (state_q == INIT) ? cnt_q : addr_arr[arb_idx];
    assign dec_full = onehot_dec(32'(dec_addr));
    assign addr_oor = |dec_full[RF_MAX_DEPTH-1:DEPTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rf_we_d    = '0;
        rf_wdata_d = rf_wdata_q;
        grant_id_d = grant_id_q;
        wr_err_d   = 1'b0;
        case (state_q)
            INIT: begin
                rf_we_d    = dec_full[DEPTH-1:0];
                rf_wdata_d = INIT_VAL;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ARB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB: begin
                if (init_start) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else if (arb_advance) begin
                    rf_we_d    = addr_oor ? '0 : dec_full[DEPTH-1:0];
                    rf_wdata_d = data_arr[arb_idx];
                    grant_id_d = arb_idx;
                    wr_err_d   = addr_oor;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            rf_we_q    <= '0;
            rf_wdata_q <= '0;
            grant_id_q <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rf_we_q    <= rf_we_d;
            rf_wdata_q <= rf_wdata_d;
            grant_id_q <= grant_id_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_wdata    = rf_wdata_q;
    assign wr_grant_id = grant_id_q;
    assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-level reference model, and a DEPTH=12 build for out-of-range writes.
module tb_regfile_wr_sched;

    localparam int N  = 4;
    localparam int D  = 16;
    localparam int W  = 32;
    localparam int AW = 4;
    localparam int IW = 2;
    localparam int D2 = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default build
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*W-1:0]  req_data;
    logic          init_start;
    logic          init_busy;
    logic [D-1:0]  rf_we;
    logic [W-1:0]  rf_wdata;
    logic [IW-1:0] wr_grant_id;
    logic          wr_err;

    logic [AW-1:0] v_addr [N];
    logic [W-1:0]  v_data [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = v_addr[i];
            req_data[i*W +: W]   = v_data[i];
        end
    end

    regfile_wr_sched #(
        .NUM_REQ (N), .DEPTH (D), .WIDTH (W), .INIT_VAL ('0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .init_start  (init_start),
        .init_busy   (init_busy),
        .rf_we       (rf_we),
        .rf_wdata    (rf_wdata),
        .wr_grant_id (wr_grant_id),
        .wr_err      (wr_err)
    );

    // DEPTH=12 build
    logic            rst2;
    logic [N-1:0]    valid2;
    logic [N-1:0]    ready2;
    logic [N*AW-1:0] addr2_bus;
    logic [N*W-1:0]  data2_bus;
    logic            init2;
    logic            busy2;
    logic [D2-1:0]   we2;
    logic [W-1:0]    wdata2;
    logic [IW-1:0]   gid2;
    logic            err2;

    regfile_wr_sched #(
        .NUM_REQ (N), .DEPTH (D2), .WIDTH (W), .INIT_VAL ('0)
    ) dut12 (
        .clk         (clk),
        .rst         (rst2),
        .req_valid   (valid2),
        .req_ready   (ready2),
        .req_addr    (addr2_bus),
        .req_data    (data2_bus),
        .init_start  (init2),
        .init_busy   (busy2),
        .rf_we       (we2),
        .rf_wdata    (wdata2),
        .wr_grant_id (gid2),
        .wr_err      (err2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: sweep flag/index, RR pointer and the expected
    // registered outputs, advanced once per clock from the behavioural rules.
    bit          m_init = 1'b0;
    int          m_k    = 0;
    int          m_ptr  = 0;
    logic [D-1:0] m_we   = '0;
    logic [W-1:0] m_wdata = '0;
    int          m_gid  = 0;
    bit          m_err  = 1'b0;
    int          m_grant = -1;

    task automatic cycle();
        logic [N-1:0] exp_ready;
        @(negedge clk);
        m_grant = -1;
        if (!rst && !m_init && !init_start) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (m_grant < 0 && req_valid[j]) m_grant = j;
            end
        end
        exp_ready = (m_grant >= 0) ? N'(1 << m_grant) : '0;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        if (!rst) check("init_busy", 64'(init_busy), 64'(m_init));

        @(posedge clk);
        if (rst) begin
            m_init = 1'b1; m_k = 0; m_ptr = 0;
            m_we = '0; m_wdata = '0; m_gid = 0; m_err = 1'b0;
        end else if (m_init) begin
            m_we = D'(1) << m_k; m_wdata = '0; m_err = 1'b0;
            m_k++;
            if (m_k == D) begin m_init = 1'b0; m_k = 0; end
        end else if (init_start) begin
            m_we = '0; m_err = 1'b0; m_init = 1'b1; m_k = 0;
        end else if (m_grant >= 0) begin
            m_we    = D'(1) << v_addr[m_grant];
            m_wdata = v_data[m_grant];
            m_gid   = m_grant;
            m_err   = 1'b0;
            m_ptr   = (m_grant + 1) % N;
        end else begin
            m_we = '0; m_err = 1'b0;
        end
        #1;
        check("rf_we", 64'(rf_we), 64'(m_we));
        check("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
        check("wr_grant_id", 64'(wr_grant_id), 64'(m_gid));
        check("wr_err", 64'(wr_err), 64'(m_err));
        check("rf_we_onehot", 64'($countones(rf_we) <= 1), 64'(1));
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; init_start = 1'b0;
        for (int i = 0; i < N; i++) begin v_addr[i] = '0; v_data[i] = '0; end
        rst2 = 1'b1; valid2 = '0; addr2_bus = '0; data2_bus = '0; init2 = 1'b0;

        // Reset, then sweep with requester 2 already waiting
        repeat (2) cycle();
        rst = 1'b0;
        req_valid[2] = 1'b1; v_addr[2] = 4'd5; v_data[2] = 32'hDEADBEEF;
        for (int c = 0; c < D; c++) begin
            cycle();
            check("sweep_we", 64'(rf_we), 64'(D'(1) << c));
        end
        cycle();
        check("first_we", 64'(rf_we), 64'(16'h0020));
        check("first_wdata", 64'(rf_wdata), 64'(32'hDEADBEEF));
        check("first_gid", 64'(wr_grant_id), 64'(2));
        req_valid[2] = 1'b0;

        // Requester 3 alone moves the pointer back to 0
        req_valid[3] = 1'b1; v_addr[3] = 4'd15; v_data[3] = 32'h3333_0000;
        cycle();
        check("gid_three", 64'(wr_grant_id), 64'(3));
        req_valid[3] = 1'b0;

        // All four valid continuously
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            v_addr[i] = 4'(8 + i);
            v_data[i] = 32'hA000_0000 + 32'(i);
        end
        for (int c = 0; c < 5; c++) begin
            cycle();
            check("rr_order", 64'(wr_grant_id), 64'(c % N));
            check("rr_we", 64'(rf_we), 64'(D'(1) << (8 + c % N)));
        end

        // init_start collides with requester 1
        req_valid = 4'b0010; v_addr[1] = 4'd3; v_data[1] = 32'h1111_2222;
        init_start = 1'b1;
        cycle();
        check("init_start_no_we", 64'(rf_we), 64'(0));
        init_start = 1'b0;
        for (int c = 0; c < D; c++) begin
            cycle();
            check("resweep_we", 64'(rf_we), 64'(D'(1) << c));
        end
        cycle();
        check("post_init_gid", 64'(wr_grant_id), 64'(1));
        check("post_init_we", 64'(rf_we), 64'(16'h0008));
        check("post_init_wdata", 64'(rf_wdata), 64'(32'h1111_2222));
        req_valid = '0;

        // Reset at sweep cycle 7
        init_start = 1'b1;
        cycle();
        init_start = 1'b0;
        repeat (7) cycle();
        rst = 1'b1;
        cycle();
        check("rst_mid_we", 64'(rf_we), 64'(0));
        rst = 1'b0;
        for (int c = 0; c < D; c++) begin
            cycle();
            check("restart_we", 64'(rf_we), 64'(D'(1) << c));
        end

        // Random traffic; requesters hold until accepted
        for (int c = 0; c < 400; c++) begin
            init_start = ($urandom_range(0, 29) == 0);
            cycle();
            for (int i = 0; i < N; i++) begin
                if (m_grant == i) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
                    req_valid[i] = 1'b1;
                    v_addr[i]    = 4'($urandom_range(0, 15));
                    v_data[i]    = $urandom();
                end
            end
        end
        init_start = 1'b0;
        req_valid  = '0;

        // DEPTH=12 build: sweep, then an out-of-range write
        rst2 = 1'b0;
        for (int c = 0; c < D2; c++) begin
            @(posedge clk); #1;
            check("d12_sweep", 64'(we2), 64'(D2'(1) << c));
        end
        valid2 = 4'b0001; addr2_bus[3:0] = 4'd13; data2_bus[31:0] = 32'h0000_CAFE;
        @(negedge clk);
        check("d12_ready0", 64'(ready2), 64'(4'b0001));
        check("d12_busy", 64'(busy2), 64'(0));
        @(posedge clk); #1;
        check("d12_oor_we", 64'(we2), 64'(0));
        check("d12_oor_err", 64'(err2), 64'(1));
        check("d12_oor_gid", 64'(gid2), 64'(0));
        valid2 = 4'b0011; addr2_bus[3:0] = 4'd2; addr2_bus[7:4] = 4'd11;
        data2_bus[63:32] = 32'h0000_BEEF;
        @(negedge clk);
        check("d12_ready1", 64'(ready2), 64'(4'b0010));
        @(posedge clk); #1;
        check("d12_err_clear", 64'(err2), 64'(0));
        check("d12_we11", 64'(we2), 64'(12'h800));
        check("d12_gid1", 64'(gid2), 64'(1));
        check("d12_wdata", 64'(wdata2), 64'(32'h0000_BEEF));
        valid2 = '0;
        @(posedge clk); #1;
        check("d12_idle_we", 64'(we2), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
